// File: rtl/sequential_multiplier_32bit_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
// FSM encoding, default operand width and counter width.
package sequential_multiplier_32bit_pkg;

    localparam int MUL_WIDTH = 32;
    localparam int CNT_W     = $clog2(MUL_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } mul_state_t;

endpackage

// File: rtl/multiplier_control.sv
// Sequencer for the shift-and-add multiplier.
// Owns the FSM and the iteration counter.
module multiplier_control
    import sequential_multiplier_32bit_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic load,
    output logic iterate,
    output logic busy,
    output logic done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mul_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        iterate = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                iterate = 1'b1;
                busy    = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/mux2.sv
// Single-bit 2:1 multiplexer cell.
// Select 0 passes d0, select 1 passes d1.
module mux2 (
    input  logic sel,
    input  logic d0,
    input  logic d1,
    output logic y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/sequential_multiplier_32bit.sv
// Unsigned shift-and-add multiplier, one bit per clock.
// Datapath registers and adder; sequencing lives in multiplier_control.
module sequential_multiplier_32bit
    import sequential_multiplier_32bit_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);

    logic load, iterate;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;

    multiplier_control #(.WIDTH(WIDTH)) u_ctrl (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .load    (load),
        .iterate (iterate),
        .busy    (busy),
        .done    (done)
    );

    // Add-or-hold: the product LSB picks the multiplicand or zero per bit
    for (genvar i = 0; i < WIDTH; i++) begin : g_sel
        mux2 u_mux (
            .sel (product[0]),
            .d0  (1'b0),
            .d1  (mcand_q[i]),
            .y   (addend[i])
        );
    end

    assign sum = {1'b0, product[2*WIDTH-1:WIDTH]} + {1'b0, addend};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            product <= '0;
        end else if (load) begin
            mcand_q <= multiplicand;
            product <= {{WIDTH{1'b0}}, multiplier};
        end else if (iterate) begin
            product <= {sum, product[WIDTH-1:1]};
        end
    end

endmodule

// File: tb/tb_sequential_multiplier_32bit.sv
// Directed self-checking bench for sequential_multiplier_32bit.
// Each scenario task drives stimulus and checks results inline.
module tb_sequential_multiplier_32bit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] product;
    logic        busy;
    logic        done;

    int checks;
    int failures;

    sequential_multiplier_32bit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (a),
        .multiplier   (b),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle start; returns 1 ns after the accepting edge
    task automatic go(input logic [31:0] ma, input logic [31:0] mb);
        @(negedge clk);
        a     = ma;
        b     = mb;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Edges counted after the accepting edge until done is seen
    task automatic wait_done(input int max, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (done) begin
                ok = 1'b1;
                n  = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        start = 1'b0;
        a     = '0;
        b     = '0;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        checks += 3;
        if (product !== 64'd0) begin
            failures++;
            $display("FAIL reset_product got=%h exp=0", product);
        end
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done got=%b exp=0", done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) tick();
        checks += 3;
        if (product !== 64'd0) begin
            failures++;
            $display("FAIL idle_product got=%h exp=0", product);
        end
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_busy got=%b exp=0", busy);
        end
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL idle_done got=%b exp=0", done);
        end
    endtask

    task automatic test_3x5();
        int n;
        bit ok;
        go(32'd3, 32'd5);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL 3x5_busy_on got=%b exp=1", busy);
        end
        wait_done(40, n, ok);
        // Done after E32, i.e. the 33rd edge counting the accepting edge
        checks += 2;
        if (!ok || n != 32) begin
            failures++;
            $display("FAIL 3x5_latency got=%0d exp=32", n);
        end
        if (product !== 64'h0000_0000_0000_000F) begin
            failures++;
            $display("FAIL 3x5_product got=%h exp=f", product);
        end
        tick();
        checks += 3;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL 3x5_done_pulse got=%b exp=0", done);
        end
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL 3x5_busy_off got=%b exp=0", busy);
        end
        if (product !== 64'h0000_0000_0000_000F) begin
            failures++;
            $display("FAIL 3x5_hold got=%h exp=f", product);
        end
    endtask

    task automatic test_carry();
        int n;
        bit ok;
        go(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(40, n, ok);
        checks++;
        if (!ok || product !== 64'hFFFF_FFFE_0000_0001) begin
            failures++;
            $display("FAIL carry_max got=%h exp=fffffffe00000001",
                     product);
        end
        tick();
        go(32'h8000_0000, 32'd2);
        wait_done(40, n, ok);
        checks++;
        if (!ok || product !== 64'h0000_0001_0000_0000) begin
            failures++;
            $display("FAIL carry_msb got=%h exp=100000000", product);
        end
        tick();
    endtask

    task automatic test_ignored_start();
        int dc;
        logic [63:0] p;
        dc = 0;
        p  = '0;
        go(32'd3, 32'd5);
        repeat (9) tick();
        @(negedge clk);
        a     = 32'd7;
        b     = 32'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) begin
                dc++;
                p = product;
            end
        end
        checks += 4;
        if (dc != 1) begin
            failures++;
            $display("FAIL ign_done_count got=%0d exp=1", dc);
        end
        if (p !== 64'd15) begin
            failures++;
            $display("FAIL ign_result got=%h exp=f", p);
        end
        if (product !== 64'd15) begin
            failures++;
            $display("FAIL ign_hold got=%h exp=f", product);
        end
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL ign_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_mid_reset();
        int dc;
        int n;
        bit ok;
        dc = 0;
        go(32'd100, 32'd200);
        repeat (16) tick();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks += 2;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL mrst_flags got=%b%b exp=00", busy, done);
        end
        if (product !== 64'd0) begin
            failures++;
            $display("FAIL mrst_product got=%h exp=0", product);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) dc++;
        end
        checks += 2;
        if (dc != 0) begin
            failures++;
            $display("FAIL mrst_no_done got=%0d exp=0", dc);
        end
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL mrst_idle got=%b exp=0", busy);
        end
        go(32'd6, 32'd7);
        wait_done(40, n, ok);
        checks++;
        if (!ok || product !== 64'd42) begin
            failures++;
            $display("FAIL mrst_6x7 got=%h exp=2a", product);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        bit ok;
        @(negedge clk);
        a     = 32'd0;
        b     = 32'd12345;
        start = 1'b1;
        tick();
        a = 32'd2;
        b = 32'd3;
        wait_done(40, n, ok);
        checks += 2;
        if (!ok || n != 32) begin
            failures++;
            $display("FAIL b2b_lat1 got=%0d exp=32", n);
        end
        if (product !== 64'd0) begin
            failures++;
            $display("FAIL b2b_zero got=%h exp=0", product);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap got=%b exp=0", busy);
        end
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || product !== 64'd3) begin
            failures++;
            $display("FAIL b2b_accept busy=%b prod=%h exp=1,3",
                     busy, product);
        end
        wait_done(40, n, ok);
        checks += 2;
        if (!ok || n != 32) begin
            failures++;
            $display("FAIL b2b_lat2 got=%0d exp=32", n);
        end
        if (product !== 64'd6) begin
            failures++;
            $display("FAIL b2b_product got=%h exp=6", product);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_3x5();
        test_carry();
        test_ignored_start();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
